// File: rtl/lowfreq_clkgen_multi.sv
// Multi-channel low-frequency clock/strobe generator with an AXI4-Lite register port.
// Each channel divides ACLK by a programmable half-period that is reloaded only at wrap.
module lowfreq_clkgen_multi #(
    parameter int unsigned NUM_CH             = 4,
    parameter int unsigned CNT_W              = 32,
    parameter int unsigned DEFAULT_HALF       = 500000,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [NUM_CH-1:0]                 clk_out,
    output logic [NUM_CH-1:0]                 tick
);
    localparam int unsigned DW        = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW        = DW / 8;
    localparam int unsigned WORD_W    = C_S_AXI_ADDR_WIDTH - 2;
    localparam int unsigned HALF_BASE = 4;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    logic              awready_q, awready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [NUM_CH-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  half_q   [NUM_CH];
    logic [CNT_W-1:0]  half_d   [NUM_CH];
    logic [CNT_W-1:0]  shadow_q [NUM_CH];
    logic [CNT_W-1:0]  shadow_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q    [NUM_CH];
    logic [CNT_W-1:0]  cnt_d    [NUM_CH];
    logic [NUM_CH-1:0] clk_q, clk_d;
    logic [NUM_CH-1:0] tick_q, tick_d;

    logic              wr_fire_c;
    logic              rd_fire_c;
    logic [WORD_W-1:0] wr_word_c;
    logic [WORD_W-1:0] rd_word_c;
    logic [NUM_CH-1:0] sync_c;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                  input logic [DW-1:0] data,
                                                  input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        res = old_v;
        for (int b = 0; b < int'(SW); b++) begin
            if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
        end
        return res;
    endfunction

    function automatic logic word_ok(input logic [WORD_W-1:0] word);
        return 32'(word) < HALF_BASE + NUM_CH;
    endfunction

    // AXI write channel and register file updates
    always_comb begin
        wr_fire_c = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
        wr_word_c = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
        awready_d = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        ctrl_d    = ctrl_q;
        half_d    = half_q;
        sync_c    = '0;
        if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
        if (wr_fire_c) begin
            bvalid_d = 1'b1;
            bresp_d  = word_ok(wr_word_c) ? RESP_OKAY : RESP_SLVERR;
            if (wr_word_c == WORD_W'(0)) begin
                ctrl_d = NUM_CH'(merge_bytes(DW'(ctrl_q), S_AXI_WDATA, S_AXI_WSTRB));
            end
            if (wr_word_c == WORD_W'(2)) begin
                for (int n = 0; n < int'(NUM_CH); n++) begin
                    sync_c[n] = S_AXI_WDATA[n] & S_AXI_WSTRB[n/8];
                end
            end
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                if (32'(wr_word_c) == HALF_BASE + n) begin
                    half_d[n] = CNT_W'(merge_bytes(DW'(half_q[n]), S_AXI_WDATA, S_AXI_WSTRB));
                end
            end
        end
    end

    // AXI read channel; samples registers before any same-edge write lands
    always_comb begin
        rd_fire_c = arready_q & S_AXI_ARVALID;
        rd_word_c = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
        arready_d = S_AXI_ARVALID & ~rvalid_q & ~arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
        if (rd_fire_c) begin
            rvalid_d = 1'b1;
            rresp_d  = word_ok(rd_word_c) ? RESP_OKAY : RESP_SLVERR;
            rdata_d  = '0;
            if (rd_word_c == WORD_W'(0)) rdata_d = DW'(ctrl_q);
            if (rd_word_c == WORD_W'(1)) rdata_d = DW'(clk_q);
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                if (32'(rd_word_c) == HALF_BASE + n) rdata_d = DW'(half_q[n]);
            end
        end
    end

    // Per-channel dividers: held idle when disabled, zero half-period or resynced
    always_comb begin
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        clk_d    = clk_q;
        tick_d   = '0;
        for (int n = 0; n < int'(NUM_CH); n++) begin
            if (!ctrl_q[n] || shadow_q[n] == '0 || sync_c[n]) begin
                cnt_d[n]    = '0;
                clk_d[n]    = 1'b0;
                shadow_d[n] = half_q[n];
            end else if (cnt_q[n] == shadow_q[n] - CNT_W'(1)) begin
                cnt_d[n]    = '0;
                clk_d[n]    = ~clk_q[n];
                tick_d[n]   = ~clk_q[n];
                shadow_d[n] = half_q[n];
            end else begin
                cnt_d[n] = cnt_q[n] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            ctrl_q    <= '0;
            clk_q     <= '0;
            tick_q    <= '0;
            for (int n = 0; n < int'(NUM_CH); n++) begin
                half_q[n]   <= CNT_W'(DEFAULT_HALF);
                shadow_q[n] <= CNT_W'(DEFAULT_HALF);
                cnt_q[n]    <= '0;
            end
        end else begin
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            ctrl_q    <= ctrl_d;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
            for (int n = 0; n < int'(NUM_CH); n++) begin
                half_q[n]   <= half_d[n];
                shadow_q[n] <= shadow_d[n];
                cnt_q[n]    <= cnt_d[n];
            end
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign clk_out       = clk_q;
    assign tick          = tick_q;

endmodule

// File: tb/tb_lowfreq_clkgen_multi.sv
// Bench for lowfreq_clkgen_multi: directed scenarios plus randomized AXI traffic,
// compared every cycle against an event-scheduled reference model.
module tb_lowfreq_clkgen_multi;
    localparam int NUM_CH       = 4;
    localparam int DEFAULT_HALF = 500000;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [5:0]  S_AXI_AWADDR;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [5:0]  S_AXI_ARADDR;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    always #5 ACLK = ~ACLK;

    lowfreq_clkgen_multi #(
        .NUM_CH(NUM_CH), .CNT_W(32), .DEFAULT_HALF(DEFAULT_HALF),
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .clk_out(clk_out), .tick(tick)
    );

    int     n_checks = 0;
    int     n_pass   = 0;
    longint cyc      = 0;
    bit     auto_chk = 1'b1;
    longint last_b   = 0;
    logic [NUM_CH-1:0] b_clk;

    // Reference model: register mirror plus absolute time of each channel's next toggle
    logic [NUM_CH-1:0] m_ctrl;
    logic [31:0]       m_half [NUM_CH];
    logic [31:0]       m_sh   [NUM_CH];
    longint            m_next [NUM_CH];
    logic [NUM_CH-1:0] m_lvl;
    logic [NUM_CH-1:0] m_tick;
    bit                pw_valid = 1'b0;
    logic [5:0]        pw_addr;
    logic [31:0]       pw_data;
    logic [3:0]        pw_strb;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic bit addr_ok(input logic [5:0] addr);
        return int'(addr[5:2]) < 4 + NUM_CH;
    endfunction

    function automatic logic [31:0] model_read(input logic [5:0] addr);
        int w;
        w = int'(addr[5:2]);
        if (w == 0) return 32'(m_ctrl);
        if (w == 1) return 32'(m_lvl);
        if (w >= 4 && w < 4 + NUM_CH) return m_half[w-4];
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_ctrl = '0;
        m_lvl  = '0;
        m_tick = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            m_half[n] = 32'(DEFAULT_HALF);
            m_sh[n]   = 32'(DEFAULT_HALF);
            m_next[n] = 0;
        end
        pw_valid = 1'b0;
    endtask

    task automatic model_advance();
        logic [NUM_CH-1:0] sync;
        int w;
        sync = '0;
        if (pw_valid && pw_addr[5:2] == 4'd2)
            for (int n = 0; n < NUM_CH; n++) sync[n] = pw_data[n] & pw_strb[n/8];
        for (int n = 0; n < NUM_CH; n++) begin
            if (!m_ctrl[n] || m_sh[n] == 32'd0 || sync[n]) begin
                m_lvl[n]  = 1'b0;
                m_tick[n] = 1'b0;
                m_sh[n]   = m_half[n];
                m_next[n] = cyc + longint'(m_half[n]);
            end else if (cyc == m_next[n]) begin
                m_lvl[n]  = ~m_lvl[n];
                m_tick[n] = m_lvl[n];
                m_sh[n]   = m_half[n];
                m_next[n] = cyc + longint'(m_half[n]);
            end else begin
                m_tick[n] = 1'b0;
            end
        end
        if (pw_valid) begin
            w = int'(pw_addr[5:2]);
            if (w == 0) m_ctrl = NUM_CH'(merge(32'(m_ctrl), pw_data, pw_strb));
            if (w >= 4 && w < 4 + NUM_CH) m_half[w-4] = merge(m_half[w-4], pw_data, pw_strb);
        end
        pw_valid = 1'b0;
    endtask

    task automatic step();
        logic rst;
        rst = ARESET;
        @(posedge ACLK);
        cyc++;
        #1;
        if (rst) model_reset();
        else model_advance();
        if (auto_chk) begin
            check("clk_out", 64'(clk_out), 64'(m_lvl));
            check("tick", 64'(tick), 64'(m_tick));
        end
    endtask

    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input bit accept);
        int guard;
        guard = 0;
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
        while (!(S_AXI_AWREADY && S_AXI_WREADY)) begin
            if (guard++ >= 16) begin
                check("aw_timeout", 64'(S_AXI_AWREADY), 64'd1);
                S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
                return;
            end
            step();
        end
        pw_valid = 1'b1; pw_addr = addr; pw_data = data; pw_strb = strb;
        step();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        last_b = cyc;
        b_clk  = clk_out;
        check("bvalid", 64'(S_AXI_BVALID), 64'd1);
        check("bresp", 64'(S_AXI_BRESP), addr_ok(addr) ? 64'd0 : 64'd2);
        if (!accept) return;
        step();
        check("bvalid_hold", 64'(S_AXI_BVALID), 64'd1);
        S_AXI_BREADY = 1'b1;
        step();
        check("bvalid_clr", 64'(S_AXI_BVALID), 64'd0);
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] addr, output logic [31:0] data);
        int guard;
        logic [31:0] exp_d;
        guard = 0;
        data = '0;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        while (!S_AXI_ARREADY) begin
            if (guard++ >= 16) begin
                check("ar_timeout", 64'(S_AXI_ARREADY), 64'd1);
                S_AXI_ARVALID = 1'b0;
                return;
            end
            step();
        end
        exp_d = model_read(addr);
        step();
        S_AXI_ARVALID = 1'b0;
        check("rvalid", 64'(S_AXI_RVALID), 64'd1);
        check("rdata", 64'(S_AXI_RDATA), 64'(exp_d));
        check("rresp", 64'(S_AXI_RRESP), addr_ok(addr) ? 64'd0 : 64'd2);
        data = S_AXI_RDATA;
        step();
        check("rdata_hold", 64'(S_AXI_RDATA), 64'(exp_d));
        S_AXI_RREADY = 1'b1;
        step();
        check("rvalid_clr", 64'(S_AXI_RVALID), 64'd0);
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic wait_tick(input int ch, output longint t);
        t = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (tick[ch]) begin
                t = cyc;
                return;
            end
        end
        check("tick_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        longint t0, t1;
        int gap_min, gap_max, nticks;
        longint last_t;
        logic prev;

        // Reset with traffic presented: nothing may be accepted or answered
        ARESET = 1'b1;
        S_AXI_AWADDR = 6'h00; S_AXI_WDATA = 32'hF; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = 6'h10; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_bvalid", 64'(S_AXI_BVALID), 64'd0);
            check("rst_rvalid", 64'(S_AXI_RVALID), 64'd0);
            check("rst_awready", 64'(S_AXI_AWREADY), 64'd0);
            check("rst_arready", 64'(S_AXI_ARREADY), 64'd0);
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        ARESET = 1'b0;
        step();
        axi_read(6'h10, d);
        check("rst_half0", 64'(d), 64'h0007A120);
        axi_read(6'h00, d);
        check("rst_ctrl", 64'(d), 64'd0);

        // H=5 on channel 0: first tick 5 cycles after BVALID, period 10
        axi_write(6'h10, 32'd5, 4'hF, 1'b1);
        axi_write(6'h00, 32'd1, 4'hF, 1'b1);
        wait_tick(0, t0);
        check("first_tick_lat", 64'(t0 - last_b), 64'd5);
        wait_tick(0, t1);
        check("period", 64'(t1 - t0), 64'd10);
        for (int i = 0; i < 3; i++) begin
            axi_read(6'h04, d);
            repeat (i + 1) step();
        end

        // SYNC realigns channels 0 and 1
        axi_write(6'h10, 32'd3, 4'hF, 1'b1);
        axi_write(6'h14, 32'd7, 4'hF, 1'b1);
        axi_write(6'h00, 32'd3, 4'hF, 1'b1);
        repeat (23) step();
        axi_write(6'h08, 32'd3, 4'hF, 1'b1);
        check("sync_low", 64'(b_clk[1:0]), 64'd0);
        t0 = -1; t1 = -1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (tick[0] && t0 < 0) t0 = cyc;
            if (tick[1] && t1 < 0) t1 = cyc;
        end
        check("sync_rise0", 64'(t0 - last_b), 64'd3);
        check("sync_rise1", 64'(t1 - last_b), 64'd7);
        axi_read(6'h08, d);

        // Half-period change mid-half: glitch-free switch from 4 to 2
        axi_write(6'h00, 32'd1, 4'hF, 1'b1);
        axi_write(6'h10, 32'd4, 4'hF, 1'b1);
        wait_tick(0, t0);
        wait_tick(0, t0);
        step();
        axi_write(6'h10, 32'd2, 4'hF, 1'b1);
        gap_min = 1000; gap_max = 0; last_t = -1; prev = clk_out[0];
        for (int i = 0; i < 20; i++) begin
            step();
            if (clk_out[0] != prev) begin
                if (last_t >= 0) begin
                    if (int'(cyc - last_t) < gap_min) gap_min = int'(cyc - last_t);
                    if (int'(cyc - last_t) > gap_max) gap_max = int'(cyc - last_t);
                end
                last_t = cyc;
                prev = clk_out[0];
            end
        end
        check("new_half_min", 64'(gap_min), 64'd2);
        check("new_half_max", 64'(gap_max), 64'd2);

        // H=0 holds the enabled channel low
        axi_write(6'h10, 32'd0, 4'hF, 1'b1);
        repeat (8) step();
        nticks = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tick[0]) nticks++;
        end
        check("h0_ticks", 64'(nticks), 64'd0);
        check("h0_clk", 64'(clk_out[0]), 64'd0);

        // Out-of-range, reserved and SYNC reads; strobe merge
        axi_write(6'h20, 32'hDEAD, 4'hF, 1'b1);
        axi_read(6'h20, d);
        check("oob_rdata", 64'(d), 64'd0);
        axi_write(6'h0C, 32'h55, 4'hF, 1'b1);
        axi_read(6'h0C, d);
        axi_read(6'h13, d);
        axi_write(6'h14, 32'hAABBCCDD, 4'b0101, 1'b1);
        axi_read(6'h14, d);
        check("strb_merge", 64'(d), 64'h00BB00DD);

        // Randomized traffic
        for (int n = 0; n < NUM_CH; n++) axi_write(6'(16 + 4*n), 32'(3 + n), 4'hF, 1'b1);
        for (int it = 0; it < 250; it++) begin
            int op;
            op = int'($urandom_range(0, 9));
            case (op)
                0, 1, 2: repeat ($urandom_range(1, 6)) step();
                3, 4, 5: axi_write(6'(16 + 4*$urandom_range(0, NUM_CH-1)),
                                   32'($urandom_range(0, 9)), 4'($urandom_range(0, 15)), 1'b1);
                6: axi_write(6'h00, 32'($urandom & 32'hF), 4'($urandom_range(0, 15)), 1'b1);
                7: axi_write(6'h08, 32'($urandom & 32'hF), 4'hF, 1'b1);
                8: axi_read(6'($urandom_range(0, 63)), d);
                default: axi_write(6'($urandom_range(0, 63)), 32'($urandom_range(0, 9)), 4'hF, 1'b1);
            endcase
        end

        // Reset mid-run with a write response pending
        axi_write(6'h00, 32'hF, 4'hF, 1'b1);
        repeat (15) step();
        axi_write(6'h10, 32'd9, 4'hF, 1'b0);
        ARESET = 1'b1;
        step();
        check("midrst_bvalid", 64'(S_AXI_BVALID), 64'd0);
        check("midrst_clk", 64'(clk_out), 64'd0);
        ARESET = 1'b0;
        step();
        axi_read(6'h10, d);
        check("midrst_half", 64'(d), 64'h0007A120);
        axi_read(6'h00, d);
        check("midrst_ctrl", 64'(d), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
